// File: rtl/io_bridge_arbiter_pkg.sv
// Shared types and constants for the IO bridge slave-side arbiter.
// Bridge data/byte-enable widths, FSM state encoding, and the requester-ID width helper.
package io_bridge_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/io_arb_pending_fifo.sv
// Synchronous FIFO of requester IDs recording who owns each outstanding read.
// Pointers wrap naturally because DEPTH is a power of two.
module io_arb_pending_fifo #(
  parameter int ID_W  = 1,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [ID_W-1:0]          push_id,
  input  logic                     pop,
  output logic [ID_W-1:0]          head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ID_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CNT_W'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];
  assign count   = cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage holds data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_id;
  end

endmodule

// File: rtl/io_bridge_arbiter.sv
// Round-robin arbiter sharing the IO clock-crossing bridge slave among NUM_REQ Avalon-MM
// requesters; read returns are steered back to their issuer in order.
module io_bridge_arbiter
  import io_bridge_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_W      = 20,
  parameter int MAX_PENDING = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ*ADDR_W-1:0]     rq_address,
  input  logic [NUM_REQ*BE_W-1:0]       rq_byteenable,
  input  logic [NUM_REQ-1:0]            rq_read,
  input  logic [NUM_REQ-1:0]            rq_write,
  input  logic [NUM_REQ*DATA_W-1:0]     rq_writedata,
  output logic [NUM_REQ-1:0]            rq_waitrequest,
  output logic [DATA_W-1:0]             rq_readdata,
  output logic [NUM_REQ-1:0]            rq_readdatavalid,
  output logic [ADDR_W-1:0]             br_address,
  output logic [BE_W-1:0]               br_byteenable,
  output logic                          br_read,
  output logic                          br_write,
  output logic [DATA_W-1:0]             br_writedata,
  input  logic                          br_waitrequest,
  input  logic [DATA_W-1:0]             br_readdata,
  input  logic                          br_readdatavalid,
  output logic [$clog2(MAX_PENDING):0]  pending_count,
  output logic                          err_orphan_rdv
);

  localparam int ID_W = id_width(NUM_REQ);

  arb_state_e        state;
  logic [ID_W-1:0]   grant;
  logic [ID_W-1:0]   last_grant;
  logic [ID_W-1:0]   pick;
  logic [ID_W-1:0]   cand;
  logic              pick_vld;
  logic [NUM_REQ-1:0] eligible;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [ID_W-1:0]   fifo_head;

  logic [ADDR_W-1:0] addr_a [NUM_REQ];
  logic [BE_W-1:0]   be_a   [NUM_REQ];
  logic [DATA_W-1:0] wd_a   [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_a[i] = rq_address[i*ADDR_W +: ADDR_W];
    assign be_a[i]   = rq_byteenable[i*BE_W +: BE_W];
    assign wd_a[i]   = rq_writedata[i*DATA_W +: DATA_W];
  end

  // A full pending FIFO only holds back reads; writes never create a return.
  assign eligible = rq_write | (rq_read & {NUM_REQ{~fifo_full}});

  // Scan downward so the candidate closest after last_grant is the one left standing.
  always_comb begin
    pick     = last_grant;
    pick_vld = 1'b0;
    cand     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = ID_W'((int'(last_grant) + k) % NUM_REQ);
      if (eligible[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    br_address     = addr_a[grant];
    br_byteenable  = be_a[grant];
    br_writedata   = wd_a[grant];
    br_read        = 1'b0;
    br_write       = 1'b0;
    rq_waitrequest = '1;
    if (state == ST_BUSY) begin
      br_write              = rq_write[grant];
      br_read               = rq_read[grant] & ~rq_write[grant];
      rq_waitrequest[grant] = br_waitrequest;
    end
  end

  assign fifo_push        = (state == ST_BUSY) & ~br_waitrequest & br_read;
  assign fifo_pop         = br_readdatavalid & ~fifo_empty & reset_n;
  assign rq_readdatavalid = fifo_pop ? (NUM_REQ'(1) << fifo_head) : '0;
  assign rq_readdata      = br_readdata;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      grant          <= '0;
      last_grant     <= ID_W'(NUM_REQ - 1);
      err_orphan_rdv <= 1'b0;
    end else begin
      if (br_readdatavalid && fifo_empty) err_orphan_rdv <= 1'b1;
      if (state == ST_IDLE) begin
        if (pick_vld) begin
          grant <= pick;
          state <= ST_BUSY;
        end
      end else if (!br_waitrequest) begin
        last_grant <= grant;
        state      <= ST_IDLE;
      end
    end
  end

  io_arb_pending_fifo #(
    .ID_W  (ID_W),
    .DEPTH (MAX_PENDING)
  ) u_pending (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .push_id (grant),
    .pop     (fifo_pop),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (pending_count)
  );

endmodule

// File: tb/tb_io_bridge_arbiter.sv
// Directed bench for io_bridge_arbiter: cycle vector tables for the basic flows,
// hand sequences for stall, full-FIFO, orphan return and mid-transfer reset.
module tb_io_bridge_arbiter;

  localparam int NUM_REQ     = 2;
  localparam int ADDR_W      = 20;
  localparam int MAX_PENDING = 8;

  logic                      clk;
  logic                      reset_n;
  logic [NUM_REQ*ADDR_W-1:0] rq_address;
  logic [NUM_REQ*4-1:0]      rq_byteenable;
  logic [NUM_REQ-1:0]        rq_read;
  logic [NUM_REQ-1:0]        rq_write;
  logic [NUM_REQ*32-1:0]     rq_writedata;
  logic [NUM_REQ-1:0]        rq_waitrequest;
  logic [31:0]               rq_readdata;
  logic [NUM_REQ-1:0]        rq_readdatavalid;
  logic [ADDR_W-1:0]         br_address;
  logic [3:0]                br_byteenable;
  logic                      br_read;
  logic                      br_write;
  logic [31:0]               br_writedata;
  logic                      br_waitrequest;
  logic [31:0]               br_readdata;
  logic                      br_readdatavalid;
  logic [3:0]                pending_count;
  logic                      err_orphan_rdv;

  int checks = 0;
  int errors = 0;

  io_bridge_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .ADDR_W      (ADDR_W),
    .MAX_PENDING (MAX_PENDING)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .rq_address       (rq_address),
    .rq_byteenable    (rq_byteenable),
    .rq_read          (rq_read),
    .rq_write         (rq_write),
    .rq_writedata     (rq_writedata),
    .rq_waitrequest   (rq_waitrequest),
    .rq_readdata      (rq_readdata),
    .rq_readdatavalid (rq_readdatavalid),
    .br_address       (br_address),
    .br_byteenable    (br_byteenable),
    .br_read          (br_read),
    .br_write         (br_write),
    .br_writedata     (br_writedata),
    .br_waitrequest   (br_waitrequest),
    .br_readdata      (br_readdata),
    .br_readdatavalid (br_readdatavalid),
    .pending_count    (pending_count),
    .err_orphan_rdv   (err_orphan_rdv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [1:0]  rd;
    logic [1:0]  wr;
    logic        bw;
    logic        rdv;
    logic        e_brd;
    logic        e_bwr;
    logic [1:0]  e_wait;
    logic [1:0]  e_rdv;
    logic [3:0]  e_pend;
    logic [19:0] e_addr;
    logic [31:0] e_data;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic [1:0] rd, input logic [1:0] wr,
                              input logic bw, input logic rdv, input logic e_brd,
                              input logic e_bwr, input logic [1:0] e_wait,
                              input logic [1:0] e_rdv, input logic [3:0] e_pend,
                              input logic [19:0] e_addr, input logic [31:0] e_data);
    vec_t v;
    v.rst = rst; v.rd = rd; v.wr = wr; v.bw = bw; v.rdv = rdv;
    v.e_brd = e_brd; v.e_bwr = e_bwr; v.e_wait = e_wait; v.e_rdv = e_rdv;
    v.e_pend = e_pend; v.e_addr = e_addr; v.e_data = e_data;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n          = 1'b0;
    rq_read          = '0;
    rq_write         = '0;
    br_waitrequest   = 1'b0;
    br_readdatavalid = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rq_address    = {20'h00020, 20'h00010};
    rq_byteenable = {4'hC, 4'hF};
    rq_writedata  = {32'h1234_5678, 32'hDEAD_BEEF};
    br_readdata   = '0;

    // single write from req0, then both requesters reading back-to-back
    tbl.push_back(mk(1, 2'b00, 2'b01, 0, 0, 0, 0, 2'b11, 2'b00, 0, 20'h0, 32'h0));
    tbl.push_back(mk(0, 2'b00, 2'b01, 0, 0, 0, 1, 2'b10, 2'b00, 0, 20'h00010, 32'hDEAD_BEEF));
    tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b11, 2'b00, 0, 20'h0, 32'h0));
    tbl.push_back(mk(1, 2'b11, 2'b00, 0, 0, 0, 0, 2'b11, 2'b00, 0, 20'h0, 32'h0));
    tbl.push_back(mk(0, 2'b11, 2'b00, 0, 0, 1, 0, 2'b10, 2'b00, 0, 20'h00010, 32'h0));
    tbl.push_back(mk(0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b11, 2'b00, 1, 20'h0, 32'h0));
    tbl.push_back(mk(0, 2'b11, 2'b00, 0, 0, 1, 0, 2'b01, 2'b00, 1, 20'h00020, 32'h0));
    tbl.push_back(mk(0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b11, 2'b00, 2, 20'h0, 32'h0));
    tbl.push_back(mk(0, 2'b11, 2'b00, 0, 0, 1, 0, 2'b10, 2'b00, 2, 20'h00010, 32'h0));
    tbl.push_back(mk(0, 2'b11, 2'b00, 0, 0, 0, 0, 2'b11, 2'b00, 3, 20'h0, 32'h0));
    tbl.push_back(mk(0, 2'b11, 2'b00, 0, 0, 1, 0, 2'b01, 2'b00, 3, 20'h00020, 32'h0));
    tbl.push_back(mk(0, 2'b00, 2'b00, 0, 1, 0, 0, 2'b11, 2'b01, 4, 20'h0, 32'h0));
    tbl.push_back(mk(0, 2'b00, 2'b00, 0, 1, 0, 0, 2'b11, 2'b10, 3, 20'h0, 32'h0));
    tbl.push_back(mk(0, 2'b00, 2'b00, 0, 1, 0, 0, 2'b11, 2'b01, 2, 20'h0, 32'h0));
    tbl.push_back(mk(0, 2'b00, 2'b00, 0, 1, 0, 0, 2'b11, 2'b10, 1, 20'h0, 32'h0));
    tbl.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 0, 2'b11, 2'b00, 0, 20'h0, 32'h0));

    do_reset();
    #1;
    chk("rst_wait", 32'(rq_waitrequest), 32'h3);
    chk("rst_brd", 32'(br_read), 32'h0);
    chk("rst_bwr", 32'(br_write), 32'h0);
    chk("rst_rdv", 32'(rq_readdatavalid), 32'h0);
    chk("rst_pend", 32'(pending_count), 32'h0);
    chk("rst_err", 32'(err_orphan_rdv), 32'h0);
    step();

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      rq_read          = tbl[i].rd;
      rq_write         = tbl[i].wr;
      br_waitrequest   = tbl[i].bw;
      br_readdatavalid = tbl[i].rdv;
      br_readdata      = 32'hA500_0000 + 32'(i);
      #1;
      chk($sformatf("v%0d_brd", i), 32'(br_read), 32'(tbl[i].e_brd));
      chk($sformatf("v%0d_bwr", i), 32'(br_write), 32'(tbl[i].e_bwr));
      chk($sformatf("v%0d_wait", i), 32'(rq_waitrequest), 32'(tbl[i].e_wait));
      chk($sformatf("v%0d_rdv", i), 32'(rq_readdatavalid), 32'(tbl[i].e_rdv));
      chk($sformatf("v%0d_pend", i), 32'(pending_count), 32'(tbl[i].e_pend));
      chk($sformatf("v%0d_rdata", i), rq_readdata, 32'hA500_0000 + 32'(i));
      if (tbl[i].e_brd || tbl[i].e_bwr)
        chk($sformatf("v%0d_addr", i), 32'(br_address), 32'(tbl[i].e_addr));
      if (tbl[i].e_bwr) begin
        chk($sformatf("v%0d_wdata", i), br_writedata, tbl[i].e_data);
        chk($sformatf("v%0d_be", i), 32'(br_byteenable), 32'hF);
      end
      step();
    end

    // req1 write stalled by the bridge for 5 cycles; req0 waiting behind it
    do_reset();
    rq_write       = 2'b10;
    br_waitrequest = 1'b1;
    #1;
    chk("s3_idle_bwr", 32'(br_write), 32'h0);
    step();
    rq_write = 2'b11;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("s3_stall%0d_bwr", c), 32'(br_write), 32'h1);
      chk($sformatf("s3_stall%0d_addr", c), 32'(br_address), 32'h00020);
      chk($sformatf("s3_stall%0d_data", c), br_writedata, 32'h1234_5678);
      chk($sformatf("s3_stall%0d_wait", c), 32'(rq_waitrequest), 32'h3);
      step();
    end
    br_waitrequest = 1'b0;
    #1;
    chk("s3_accept_wait", 32'(rq_waitrequest), 32'h1);
    chk("s3_accept_be", 32'(br_byteenable), 32'hC);
    step();
    rq_write = 2'b01;
    #1;
    chk("s3_gap_bwr", 32'(br_write), 32'h0);
    step();
    #1;
    chk("s3_next_bwr", 32'(br_write), 32'h1);
    chk("s3_next_addr", 32'(br_address), 32'h00010);
    chk("s3_next_wait", 32'(rq_waitrequest), 32'h2);
    step();
    rq_write = '0;

    // fill the pending FIFO, then a write passes while a read waits for a free slot
    do_reset();
    rq_read = 2'b01;
    for (int c = 0; c < 16; c++) step();
    rq_read  = 2'b10;
    rq_write = 2'b01;
    #1;
    chk("s4_full_pend", 32'(pending_count), 32'h8);
    chk("s4_full_brd", 32'(br_read), 32'h0);
    step();
    #1;
    chk("s4_wr_bwr", 32'(br_write), 32'h1);
    chk("s4_wr_brd", 32'(br_read), 32'h0);
    chk("s4_wr_addr", 32'(br_address), 32'h00010);
    step();
    rq_write = '0;
    #1;
    chk("s4_blk_brd", 32'(br_read), 32'h0);
    chk("s4_blk_wait", 32'(rq_waitrequest), 32'h3);
    step();
    br_readdatavalid = 1'b1;
    #1;
    chk("s4_ret_rdv", 32'(rq_readdatavalid), 32'h1);
    chk("s4_ret_brd", 32'(br_read), 32'h0);
    step();
    br_readdatavalid = 1'b0;
    #1;
    chk("s4_freed_pend", 32'(pending_count), 32'h7);
    step();
    #1;
    chk("s4_rd_brd", 32'(br_read), 32'h1);
    chk("s4_rd_addr", 32'(br_address), 32'h00020);
    chk("s4_rd_wait", 32'(rq_waitrequest), 32'h1);
    step();
    rq_read = '0;
    #1;
    chk("s4_refill_pend", 32'(pending_count), 32'h8);

    // readdatavalid with nothing outstanding
    do_reset();
    br_readdatavalid = 1'b1;
    #1;
    chk("s5_orphan_rdv", 32'(rq_readdatavalid), 32'h0);
    chk("s5_err_before", 32'(err_orphan_rdv), 32'h0);
    step();
    br_readdatavalid = 1'b0;
    #1;
    chk("s5_err_set", 32'(err_orphan_rdv), 32'h1);
    step();
    step();
    chk("s5_err_sticky", 32'(err_orphan_rdv), 32'h1);
    do_reset();
    #1;
    chk("s5_err_cleared", 32'(err_orphan_rdv), 32'h0);

    // reset with reads in flight drops them
    rq_read = 2'b01;
    for (int c = 0; c < 6; c++) step();
    #1;
    chk("s6_pend3", 32'(pending_count), 32'h3);
    reset_n = 1'b0;
    rq_read = '0;
    step();
    reset_n = 1'b1;
    #1;
    chk("s6_pend0", 32'(pending_count), 32'h0);
    chk("s6_idle_wait", 32'(rq_waitrequest), 32'h3);
    chk("s6_idle_brd", 32'(br_read), 32'h0);
    br_readdatavalid = 1'b1;
    #1;
    chk("s6_late_rdv", 32'(rq_readdatavalid), 32'h0);
    step();
    br_readdatavalid = 1'b0;
    #1;
    chk("s6_late_err", 32'(err_orphan_rdv), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
